pll_mdrp_responder: RTL

- Synthesizable responder for the PLL MDRP dynamic-reconfiguration port: the target end of the interface that the PLL init sequencer drives.
- Holds a 256x8 register file with an internal auto-increment address pointer, and executes read/write opcodes.
- Models PLL lock from the programmed contents.
- Used as the PLL stand-in for sequencer simulation on the tang_primer_25k board build, and as a soft register bank for bring-up.

---
 rtl/pll_mdrp_pkg.sv | 26 ++
 rtl/pll_lock_model.sv | 62 ++++++
 rtl/pll_mdrp_responder.sv | 82 ++++++++
 3 files changed

// File: rtl/pll_mdrp_pkg.sv
// Shared MDRP definitions: opcodes, lock-model states and the default PLL register map.
// Also used by the init sequencer bench.
package pll_mdrp_pkg;

   localparam logic [1:0] MDRP_NOP = 2'b00;
   localparam logic [1:0] MDRP_WR  = 2'b01;
   localparam logic [1:0] MDRP_RD  = 2'b10;
   localparam logic [1:0] MDRP_RSV = 2'b11;

   typedef enum logic [1:0] {
      LOCK_IDLE   = 2'd0,
      LOCK_COUNT  = 2'd1,
      LOCK_LOCKED = 2'd2
   } lockState_t;

   localparam logic [7:0] REG_ADDR_DIV_LO = 8'h0B;
   localparam logic [7:0] REG_ADDR_DIV_HI = 8'h0C;
   localparam logic [7:0] REG_ADDR_LOCK   = 8'h11;
   localparam logic [7:0] REG_ADDR_CTRL   = 8'h12;

   function automatic logic cfgMatches(input logic [7:0] regVal, input logic [7:0] mask,
                                       input logic [7:0] val);
      return (regVal & mask) == val;
   endfunction

endpackage

// File: rtl/pll_lock_model.sv
// PLL lock emulation: once the configuration matches and PLL reset is released,
// lock asserts after a fixed delay. PLL reset or any register write restarts it.
module pll_lock_model
   import pll_mdrp_pkg::*;
#(
   parameter int LOCK_DLY = 200
) (
   input  logic I_MD_CLK,
   input  logic I_RST_N,
   input  logic I_PLL_RST,
   input  logic I_WR_STROBE,
   input  logic I_CFG_MATCH,
   output logic O_LOCK
);

   localparam int LW = $clog2(LOCK_DLY + 1);
   localparam logic [LW-1:0] CNT_LAST = LW'(LOCK_DLY - 1);
   localparam logic [LW-1:0] CNT_MAX  = LW'(LOCK_DLY);

   localparam logic [1:0] ST_IDLE   = LOCK_IDLE;
   localparam logic [1:0] ST_COUNT  = LOCK_COUNT;
   localparam logic [1:0] ST_LOCKED = LOCK_LOCKED;

   generate
      if (LOCK_DLY < 1) begin : gBadDelay
         $error("pll_lock_model: LOCK_DLY must be at least 1");
      end
   endgenerate

   logic [1:0]    stateReg;
   logic [LW-1:0] cntReg;

   always_ff @(posedge I_MD_CLK) begin
      if (!I_RST_N) begin
         stateReg <= ST_IDLE;
         cntReg   <= '0;
      end else if (I_PLL_RST || I_WR_STROBE) begin
         stateReg <= ST_IDLE;
         cntReg   <= '0;
      end else begin
         case (stateReg)
            ST_IDLE: begin
               cntReg <= '0;
               if (I_CFG_MATCH) stateReg <= ST_COUNT;
            end
            ST_COUNT: begin
               if (cntReg == CNT_LAST) stateReg <= ST_LOCKED;
               // Counter saturates at LOCK_DLY so it can never wrap back into COUNT range.
               if (cntReg != CNT_MAX) cntReg <= cntReg + 1'b1;
            end
            ST_LOCKED: stateReg <= ST_LOCKED;
            default: begin
               stateReg <= ST_IDLE;
               cntReg   <= '0;
            end
         endcase
      end
   end

   assign O_LOCK = (stateReg == ST_LOCKED);

endmodule

// File: rtl/pll_mdrp_responder.sv
// MDRP target: 256x8 register file behind an auto-increment pointer, executing
// nop/write/read opcodes, with a lock model driven by the programmed contents.
module pll_mdrp_responder
   import pll_mdrp_pkg::*;
#(
   parameter int         LOCK_DLY  = 200,
   parameter logic [7:0] LOCK_ADDR = 8'h11,
   parameter logic [7:0] LOCK_MASK = 8'h07,
   parameter logic [7:0] LOCK_VAL  = 8'h07
) (
   input  logic       I_MD_CLK,
   input  logic       I_RST_N,
   input  logic       I_PLL_RST,
   input  logic       I_MD_INC,
   input  logic [1:0] I_MD_OPC,
   input  logic [7:0] I_MD_WR_DATA,
   output logic [7:0] O_MD_RD_DATA,
   output logic       O_LOCK,
   output logic [7:0] O_MD_ADDR,
   output logic       O_ERR
);

   logic [7:0] regFile [256];
   logic [7:0] mdAddrReg;
   logic [7:0] rdDataReg;
   logic       errReg;
   logic [7:0] effAddr;
   logic       wrEn;
   logic       lockMatch;

   // While the PLL is held out of reset the pointer is forced to 0, so accesses land at 0.
   assign effAddr = I_PLL_RST ? mdAddrReg : 8'h00;
   assign wrEn    = (I_MD_OPC == MDRP_WR);

   generate
      for (genvar gi = 0; gi < 256; gi++) begin : gRegs
         always_ff @(posedge I_MD_CLK) begin
            if (!I_RST_N)
               regFile[gi] <= 8'h00;
            else if (wrEn && (effAddr == 8'(gi)))
               regFile[gi] <= I_MD_WR_DATA;
         end
      end
   endgenerate

   always_ff @(posedge I_MD_CLK) begin
      if (!I_RST_N) begin
         mdAddrReg <= 8'h00;
         rdDataReg <= 8'h00;
         errReg    <= 1'b0;
      end else begin
         if (!I_PLL_RST)
            mdAddrReg <= 8'h00;
         else if (I_MD_INC)
            mdAddrReg <= mdAddrReg + 8'h01;

         if (I_MD_OPC == MDRP_RD)
            rdDataReg <= regFile[effAddr];

         if ((I_MD_OPC == MDRP_RSV) || (wrEn && !I_PLL_RST))
            errReg <= 1'b1;
      end
   end

   assign lockMatch = cfgMatches(regFile[LOCK_ADDR], LOCK_MASK, LOCK_VAL);

   pll_lock_model #(
      .LOCK_DLY (LOCK_DLY)
   ) uLockModel (
      .I_MD_CLK    (I_MD_CLK),
      .I_RST_N     (I_RST_N),
      .I_PLL_RST   (I_PLL_RST),
      .I_WR_STROBE (wrEn),
      .I_CFG_MATCH (lockMatch),
      .O_LOCK      (O_LOCK)
   );

   assign O_MD_RD_DATA = rdDataReg;
   assign O_MD_ADDR    = mdAddrReg;
   assign O_ERR        = errReg;

endmodule
